// File: rtl/param_pkg.sv
// Shared definitions for the parameter-load controller: state encodings and default sizes.
package param_pkg;

  localparam int DATA_W_DEF     = 8;
  localparam int NUM_PARAMS_DEF = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_WAIT = 2'd2
  } state_t;

endpackage

// File: rtl/param_load_cu_rise_detect.sv
// Rising-edge detector for the load request; the history register only advances on enabled cycles.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic sig,
  output logic rise
);

  logic sig_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q <= 1'b0;
    end else if (enable) begin
      sig_q <= sig;
    end
  end

  assign rise = sig & ~sig_q;

endmodule

// File: rtl/param_load_cu.sv
// Parameter-load control unit: collects NUM_PARAMS words per burst and writes them
// into the parameter bank with a one-cycle registered write strobe.
//
// state  | meaning
// IDLE   | waiting for a rising edge on load_params
// LOAD   | accepting words, one per data_valid
// WAIT   | burst complete; hold until load_params drops
module param_load_cu
  import param_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int NUM_PARAMS = NUM_PARAMS_DEF,
  parameter int ADDR_W     = $clog2(NUM_PARAMS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              load_params,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] data_in,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              abort_err
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_PARAMS - 1);

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic              start;
  logic              accept;
  logic              last_word;
  logic              abort_set;
  logic              abort_clr;

  rise_detect u_rise (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .sig    (load_params),
    .rise   (start)
  );

  assign last_word = (cnt == CNT_LAST);

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    accept    = 1'b0;
    abort_set = 1'b0;
    abort_clr = 1'b0;
    if (enable) begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state_d   = S_LOAD;
            cnt_d     = '0;
            abort_clr = 1'b1;
          end
        end
        S_LOAD: begin
          if (data_valid) begin
            accept = 1'b1;
            if (last_word) begin
              state_d = S_WAIT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt + ADDR_W'(1);
            end
          end
          // A request drop aborts, unless the same cycle delivered the final word.
          if (!load_params && !(data_valid && last_word)) begin
            state_d   = S_IDLE;
            cnt_d     = '0;
            abort_set = 1'b1;
          end
        end
        S_WAIT: begin
          if (!load_params) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      abort_err <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      wr_en <= accept;
      if (accept) begin
        wr_addr <= cnt;
        wr_data <= data_in;
      end
      busy <= (state_d == S_LOAD);
      done <= (state_d == S_WAIT);
      if (abort_clr) begin
        abort_err <= 1'b0;
      end else if (abort_set) begin
        abort_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_param_load_cu.sv
// Directed bench for param_load_cu: a vector table for single-cycle behaviour plus
// hand-written gap and stall sequences.
module tb_param_load_cu;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int AW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          load_params;
  logic          data_valid;
  logic [DW-1:0] data_in;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;
  logic          abort_err;

  int n_vec = 0;
  int n_err = 0;

  param_load_cu #(.DATA_W(DW), .NUM_PARAMS(NP), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .load_params(load_params),
    .data_valid (data_valid),
    .data_in    (data_in),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .abort_err  (abort_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          r;
    logic          en;
    logic          lp;
    logic          dv;
    logic [DW-1:0] din;
    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic          bsy;
    logic          dn;
    logic          abt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, en, lp, dv, input logic [DW-1:0] din,
                     input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic bsy, dn, abt);
    vec_t v;
    v.r = r; v.en = en; v.lp = lp; v.dv = dv; v.din = din;
    v.we = we; v.wa = wa; v.wd = wd; v.bsy = bsy; v.dn = dn; v.abt = abt;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, en, lp, dv, input logic [DW-1:0] din);
    rst = r; enable = en; load_params = lp; data_valid = dv; data_in = din;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    int exp_addr;
    int pulses;
    logic [DW-1:0] exp_data [NP];

    rst = 1'b1; enable = 1'b0; load_params = 1'b0; data_valid = 1'b0; data_in = '0;

    //   r  en lp dv din     we wa wd     bsy dn abt
    add(1, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0);  // reset
    add(1, 0, 1, 1, 8'h5A,  0, 0, 8'h00, 0, 0, 0);  // reset wins over enable=0
    add(0, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0);  // start burst
    add(0, 1, 1, 1, 8'h11,  1, 0, 8'h11, 1, 0, 0);
    add(0, 1, 1, 1, 8'h22,  1, 1, 8'h22, 1, 0, 0);
    add(0, 1, 1, 1, 8'h33,  1, 2, 8'h33, 1, 0, 0);
    add(0, 1, 1, 1, 8'h44,  1, 3, 8'h44, 0, 1, 0);  // last word -> WAIT
    add(0, 1, 1, 1, 8'h55,  0, 0, 8'h00, 0, 1, 0);  // WAIT ignores data
    add(0, 1, 1, 1, 8'h66,  0, 0, 8'h00, 0, 1, 0);
    add(0, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0);  // drop -> IDLE
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0);  // rearm
    add(0, 1, 1, 1, 8'h77,  1, 0, 8'h77, 1, 0, 0);
    add(0, 1, 1, 1, 8'h88,  1, 1, 8'h88, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 1);  // abort after 2 words
    add(0, 1, 0, 1, 8'h99,  0, 0, 8'h00, 0, 0, 1);  // no write in IDLE
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0);  // restart clears abort
    add(0, 1, 1, 1, 8'hAA,  1, 0, 8'hAA, 1, 0, 0);  // restart at addr 0
    add(0, 1, 0, 1, 8'hBB,  1, 1, 8'hBB, 0, 0, 1);  // accept then abort
    add(0, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 1);
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 1, 1, 8'hC1,  1, 0, 8'hC1, 1, 0, 0);
    add(1, 1, 1, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0);  // reset mid-burst
    add(0, 1, 0, 1, 8'hD0,  0, 0, 8'h00, 0, 0, 0);  // no write follows
    add(0, 0, 1, 0, 8'h00,  0, 0, 8'h00, 0, 0, 0);  // edge not seen while disabled
    add(0, 1, 1, 0, 8'h00,  0, 0, 8'h00, 1, 0, 0);
    add(0, 1, 0, 0, 8'h00,  0, 0, 8'h00, 0, 0, 1);

    foreach (vecs[i]) begin
      vec_t v;
      logic ok;
      v = vecs[i];
      step(v.r, v.en, v.lp, v.dv, v.din);
      ok = (wr_en === v.we) && (busy === v.bsy) && (done === v.dn) && (abort_err === v.abt);
      if (v.we) ok = ok && (wr_addr === v.wa) && (wr_data === v.wd);
      n_vec++;
      if (!ok) begin
        n_err++;
        $display("FAIL vec%0d: got we=%b addr=%0d data=%h busy=%b done=%b abt=%b expected we=%b addr=%0d data=%h busy=%b done=%b abt=%b",
                 i, wr_en, wr_addr, wr_data, busy, done, abort_err,
                 v.we, v.wa, v.wd, v.bsy, v.dn, v.abt);
      end
    end

    // Gapped burst: data_valid every third cycle.
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    exp_addr = 0;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      logic dv;
      dv = (i % 3 == 2);
      step(0, 1, 1, dv, DW'(8'h10 + i));
      chk("gap_we", int'(wr_en), int'(dv));
      if (wr_en) begin
        chk("gap_addr", int'(wr_addr), exp_addr);
        chk("gap_data", int'(wr_data), 8'h10 + i);
        exp_addr++;
        pulses++;
      end
    end
    chk("gap_pulses", pulses, NP);
    chk("gap_done", int'(done), 1);
    chk("gap_busy", int'(busy), 0);

    // Stall: enable low for 5 cycles mid-burst with data_valid held.
    exp_data = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
    step(0, 1, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h00);
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 1, 1, exp_data[k]);
      chk("stall_pre_we", int'(wr_en), 1);
      chk("stall_pre_addr", int'(wr_addr), k);
    end
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 1, 1, 8'hF0);
      chk("stall_we", int'(wr_en), 0);
    end
    chk("stall_busy", int'(busy), 1);
    for (int k = 2; k < NP; k++) begin
      step(0, 1, 1, 1, exp_data[k]);
      chk("stall_post_we", int'(wr_en), 1);
      chk("stall_post_addr", int'(wr_addr), k);
      chk("stall_post_data", int'(wr_data), int'(exp_data[k]));
    end
    chk("stall_done", int'(done), 1);
    chk("stall_abort", int'(abort_err), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/param_load_cu.md
PARAM_LOAD_CU -- requirements
Module: param_load_cu

Interface
REQ-001 Parameter DATA_W, default 8: width of one parameter word.
REQ-002 Parameter NUM_PARAMS, default 4 (legal range 2..256): words per load burst.
REQ-003 Parameter ADDR_W, default $clog2(NUM_PARAMS): width of wr_addr.
REQ-004 clk  input  1  single clock; all logic on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 enable  input  1  global advance qualifier; low freezes the FSM and counters.
REQ-007 load_params  input  1  level request; its rising edge starts a burst, and it is held high for the burst.
REQ-008 data_valid  input  1  strobe; data_in holds a word this cycle.
REQ-009 data_in  input  DATA_W  parameter word.
REQ-010 wr_en  output  1  one-cycle write strobe to the parameter register bank.
REQ-011 wr_addr  output  ADDR_W  target word index for wr_en.
REQ-012 wr_data  output  DATA_W  word to write.
REQ-013 busy  output  1  high in LOAD.
REQ-014 done  output  1  high in WAIT (all NUM_PARAMS words written).
REQ-015 abort_err  output  1  sticky; the last burst was aborted.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD and WAIT, and SHALL change state or counters only in cycles where enable=1.
REQ-017 The block SHALL register load_params into load_q every cycle enable=1, and SHALL define start as load_params=1 and load_q=0.
REQ-018 IDLE SHALL go to LOAD on start, clearing word count cnt to 0 and clearing abort_err.
REQ-019 In LOAD, enable=1 with data_valid=1 SHALL register wr_data=data_in and wr_addr=cnt, and SHALL assert wr_en in the next cycle only, for 1-cycle latency.
REQ-020 cnt SHALL increment by 1 per accepted word; the word accepted with cnt=NUM_PARAMS-1 SHALL move the FSM to WAIT and reset cnt to 0, and cnt SHALL never exceed NUM_PARAMS-1.
REQ-021 LOAD with load_params=0 and no data_valid SHALL go to IDLE and set abort_err=1; words already written SHALL remain written.
REQ-022 LOAD with load_params=0 and data_valid=1 in the same cycle SHALL accept the word first, then abort.
REQ-023 WAIT SHALL ignore data_valid, and SHALL go to IDLE when load_params=0.
REQ-024 With load_params still high in WAIT, no new burst SHALL start, because no rising edge has occurred.
REQ-025 wr_en SHALL be 0 in any cycle following enable=0, and SHALL never be asserted for a word accepted while enable=0.
REQ-026 busy, done and abort_err SHALL be registered outputs, decoded from state and flags with no combinational path from any input.
REQ-027 Invalid state encodings SHALL recover to IDLE on the next enabled cycle.

Reset
REQ-028 On rst=1 at a clock edge, regardless of enable: state=IDLE, cnt=0, load_q=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, abort_err=0.
REQ-029 Reset asserted mid-burst SHALL discard the burst without setting abort_err, and no wr_en SHALL follow.

Structure
REQ-030 State encodings (IDLE=2'd0, LOAD=2'd1, WAIT=2'd2) and default DATA_W/NUM_PARAMS SHALL live in the shared package param_pkg.
REQ-031 The block SHALL be flat, with one optional sub-module, rise_detect, for load_params edge detection.

Verification
REQ-032 Burst: NUM_PARAMS=4, enable=1, load_params rises, data 0x11,0x22,0x33,0x44 on consecutive cycles -> wr_en pulses at addr 0..3 with matching data one cycle later; done=1 after the 4th; busy=0.
REQ-033 Gaps: same burst with data_valid every 3rd cycle -> exactly 4 wr_en pulses, addresses 0..3 in order.
REQ-034 Abort: load_params drops after 2 words -> IDLE, abort_err=1, no further wr_en; the next rising edge clears abort_err and restarts at addr 0.
REQ-035 Stall: enable=0 for 5 cycles mid-burst while data_valid=1 -> no wr_en and cnt frozen; resuming completes at the correct addresses.
REQ-036 Hold/rearm: load_params held high after done, extra data_valid -> no wr_en; drop then raise -> new burst at addr 0.
REQ-037 Reset: rst=1 on the cycle after word 1 -> all outputs 0, abort_err=0, state IDLE.
